// File: rtl/ff_bank_pkg.sv
// Shared encodings for the flip-flop bank: cell mode and SR forbidden-input policy.
package ff_bank_pkg;

  typedef enum logic [1:0] {
    MODE_SR = 2'd0,
    MODE_JK = 2'd1,
    MODE_D  = 2'd2,
    MODE_T  = 2'd3
  } mode_e;

  localparam int POL_HOLD   = 0;
  localparam int POL_TOGGLE = 1;
  localparam int POL_SET    = 2;
  localparam int POL_RESET  = 3;

endpackage

// File: rtl/ff_cell.sv
// One storage channel whose next-state equation is selected by mode.
// ev flags an SR forbidden input (S=R=1) sampled at this edge.
module ff_cell
  import ff_bank_pkg::*;
#(
  parameter int   SR_POLICY = POL_HOLD,
  parameter logic INIT_BIT  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic       a,
  input  logic       b,
  output logic       q,
  output logic       ev
);

  logic q_nxt;

  // Next-state equation for the selected cell type.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
    q_nxt = q;
    ev    = 1'b0;
    if (en) begin
      unique case (mode_e'(mode))
        MODE_SR: begin
          unique case ({a, b})
            2'b10:   q_nxt = 1'b1;
            2'b01:   q_nxt = 1'b0;
            2'b11: begin
              ev = 1'b1;
              case (SR_POLICY)
                POL_TOGGLE: q_nxt = ~q;
                POL_SET:    q_nxt = 1'b1;
                POL_RESET:  q_nxt = 1'b0;
                default:    q_nxt = q;
              endcase
            end
            default: q_nxt = q;
          endcase
        end
        MODE_JK: begin
          unique case ({a, b})
            2'b10:   q_nxt = 1'b1;
            2'b01:   q_nxt = 1'b0;
            2'b11:   q_nxt = ~q;
            default: q_nxt = q;
          endcase
        end
        MODE_D:  q_nxt = a;
        MODE_T:  q_nxt = a ? ~q : q;
        default: q_nxt = q;
      endcase
    end
  end

  // State register with synchronous reset to the channel's initial value.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (rst) q <= INIT_BIT;
    else     q <= q_nxt;
  end

endmodule

// File: rtl/flip_flop_bank.sv
// Multi-channel mode-selectable flip-flop bank with sticky SR forbidden-input
// flags and a saturating count of cycles that saw at least one forbidden input.
module flip_flop_bank
  import ff_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               CNT_W     = 8,
  parameter int               SR_POLICY = POL_HOLD,
  parameter logic [WIDTH-1:0] INIT      = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic [WIDTH-1:0] err_flag,
  output logic [CNT_W-1:0] err_count
);

  logic [WIDTH-1:0] ev;
  logic             any_ev;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    ff_cell #(
      .SR_POLICY (SR_POLICY),
      .INIT_BIT  (INIT[i])
    ) u_cell (
      .clk  (clk),
      .rst  (rst),
      .en   (en),
      .mode (mode),
      .a    (a[i]),
      .b    (b[i]),
      .q    (q[i]),
      .ev   (ev[i])
    );
  end

  assign qn     = ~q;
  assign any_ev = |ev;

  // Sticky flags: a clear drops old history, but an event in the same cycle still lands.
  always_ff @(posedge clk) begin
    if (rst) err_flag <= '0;
    else     err_flag <= (err_clr ? '0 : err_flag) | ev;
  end

  // Counts faulting cycles (not channels) and sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst)                                err_count <= '0;
    else if (err_clr)                       err_count <= any_ev ? CNT_W'(1) : '0;
    else if (any_ev && (err_count != '1))   err_count <= err_count + CNT_W'(1);
  end

endmodule

// File: tb/tb_flip_flop_bank.sv
// Directed bench for flip_flop_bank: one instance per SR policy, shared stimulus.
module tb_flip_flop_bank;

  localparam int W = 4;
  localparam int C = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   mode;
  logic         en;
  logic [W-1:0] a, b;
  logic         err_clr;

  logic [W-1:0] q   [4];
  logic [W-1:0] qn  [4];
  logic [W-1:0] flg [4];
  logic [C-1:0] cnt [4];

  int checks   = 0;
  int failures = 0;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    flip_flop_bank #(
      .WIDTH     (W),
      .CNT_W     (C),
      .SR_POLICY (p),
      .INIT      (4'b0000)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode),
      .en        (en),
      .a         (a),
      .b         (b),
      .err_clr   (err_clr),
      .q         (q[p]),
      .qn        (qn[p]),
      .err_flag  (flg[p]),
      .err_count (cnt[p])
    );
  end

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] m, input logic e, input logic [W-1:0] va,
                       input logic [W-1:0] vb, input logic clr, input logic r);
    mode = m; en = e; a = va; b = vb; err_clr = clr; rst = r;
  endtask

  initial begin
    // Reset held for two edges with forbidden inputs present.
    drive(2'd0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b1);
    tick(); tick();
    check("rst_q",   q[0],   4'h0);
    check("rst_qn",  qn[0],  4'hF);
    check("rst_flg", flg[0], 4'h0);
    check("rst_cnt", cnt[0], 3'd0);
    check("rst_q_p1", q[1],  4'h0);

    // SR sequence on channel 0.
    drive(2'd0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    check("sr_hold", q[0], 4'h0);
    drive(2'd0, 1'b1, 4'h1, 4'h0, 1'b0, 1'b0); tick();
    check("sr_set", q[0], 4'h1);
    check("sr_set_qn", qn[0], 4'hE);
    drive(2'd0, 1'b1, 4'h0, 4'h1, 1'b0, 1'b0); tick();
    check("sr_reset", q[0], 4'h0);
    drive(2'd0, 1'b1, 4'h1, 4'h1, 1'b0, 1'b0); tick();
    check("sr_bad_q",   q[0],   4'h0);
    check("sr_bad_flg", flg[0], 4'h1);
    check("sr_bad_cnt", cnt[0], 3'd1);
    check("sr_bad_tog_p1", q[1], 4'h1);
    drive(2'd0, 1'b1, 4'h0, 4'h0, 1'b0, 1'b0); tick();
    check("sr_after_q",   q[0],   4'h0);
    check("sr_after_flg", flg[0], 4'h1);
    check("sr_after_cnt", cnt[0], 3'd1);

    // Mode coverage: JK 11 toggles and is not a forbidden event.
    drive(2'd1, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0); tick();
    check("jk_tog1", q[0], 4'hF);
    tick();
    check("jk_tog2", q[0], 4'h0);
    check("jk_cnt",  cnt[0], 3'd1);
    check("jk_flg",  flg[0], 4'h1);
    drive(2'd2, 1'b1, 4'hA, 4'h0, 1'b0, 1'b0); tick();
    check("d_load", q[0], 4'hA);
    drive(2'd3, 1'b1, 4'h3, 4'h0, 1'b0, 1'b0); tick();
    check("t_tog", q[0], 4'h9);
    check("t_tog_qn", qn[0], 4'h6);

    // Load 0101 with a clear (no event) so the policy sweep starts clean.
    drive(2'd2, 1'b1, 4'h5, 4'h0, 1'b1, 1'b0); tick();
    check("clr_q",   q[0],   4'h5);
    check("clr_flg", flg[0], 4'h0);
    check("clr_cnt", cnt[0], 3'd0);

    // One forbidden cycle on every channel under each SR policy.
    drive(2'd0, 1'b1, 4'hF, 4'hF, 1'b0, 1'b0); tick();
    check("pol_hold_q",   q[0], 4'h5);
    check("pol_toggle_q", q[1], 4'hA);
    check("pol_set_q",    q[2], 4'hF);
    check("pol_reset_q",  q[3], 4'h0);
    check("pol_toggle_flg", flg[1], 4'hF);
    check("pol_set_flg",    flg[2], 4'hF);
    check("pol_reset_flg",  flg[3], 4'hF);
    check("pol_toggle_cnt", cnt[1], 3'd1);
    check("pol_set_cnt",    cnt[2], 3'd1);
    check("pol_reset_cnt",  cnt[3], 3'd1);

    // Saturation: 9 consecutive forbidden cycles in total.
    for (int i = 0; i < 5; i++) tick();
    check("sat_cnt6", cnt[0], 3'd6);
    tick();
    check("sat_cnt7", cnt[0], 3'd7);
    tick(); tick();
    check("sat_hold", cnt[0], 3'd7);
    check("sat_q", q[0], 4'h5);

    // Clear with no event.
    drive(2'd0, 1'b1, 4'h0, 4'h0, 1'b1, 1'b0); tick();
    check("clr2_flg", flg[0], 4'h0);
    check("clr2_cnt", cnt[0], 3'd0);

    // Clear coincident with a forbidden event on channel 2.
    drive(2'd0, 1'b1, 4'h4, 4'h4, 1'b1, 1'b0); tick();
    check("clr_ev_flg", flg[0], 4'h4);
    check("clr_ev_cnt", cnt[0], 3'd1);
    check("clr_ev_q",   q[0],   4'h5);

    // Enable low: no update, no events.
    drive(2'd2, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0); tick();
    check("en0_d_q",   q[0],   4'h5);
    check("en0_d_cnt", cnt[0], 3'd1);
    drive(2'd0, 1'b0, 4'hF, 4'hF, 1'b0, 1'b0); tick();
    check("en0_sr_flg", flg[0], 4'h4);
    check("en0_sr_cnt", cnt[0], 3'd1);
    check("en0_sr_q",   q[0],   4'h5);

    // Enable low with clear: clear applies, q holds.
    drive(2'd2, 1'b0, 4'hF, 4'h0, 1'b1, 1'b0); tick();
    check("en0_clr_flg", flg[0], 4'h0);
    check("en0_clr_q",   q[0],   4'h5);

    // Reset overrides clear, enable and a forbidden input.
    drive(2'd0, 1'b1, 4'hF, 4'hF, 1'b1, 1'b1); tick();
    check("rst2_q",   q[0],   4'h0);
    check("rst2_qn",  qn[0],  4'hF);
    check("rst2_flg", flg[0], 4'h0);
    check("rst2_cnt", cnt[0], 3'd0);
    check("rst2_q_p2", q[2], 4'h0);

    // First edge after reset deasserts updates normally.
    drive(2'd2, 1'b1, 4'h6, 4'h0, 1'b0, 1'b0); tick();
    check("post_rst_q", q[0], 4'h6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
